// File: rtl/g25_hex_page_sequencer.sv
// Pages a NUM_WORDS x 32-bit digest onto the HEX3..HEX0 PIO, four hex digits per page, over Avalon-MM.
// Optional G25_HEX_LOOP_EN: wrap back to page 0 after the last dwell instead of finishing.
module g25_hex_page_sequencer #(
    parameter int unsigned  TICKS_PER_STEP = 50000000,
    parameter int unsigned  NUM_WORDS      = 8,
    localparam int unsigned ADDR_W         = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    output logic [ADDR_W-1:0] hash_word_addr,
    input  logic [31:0]       hash_word_in,
    output logic [1:0]        pio_address,
    output logic              pio_chipselect,
    output logic              pio_write_n,
    output logic [31:0]       pio_writedata,
    input  logic              pio_waitrequest,
    output logic              busy,
    output logic              done
);

    localparam int unsigned       PAGE_W    = ADDR_W + 1;
    localparam int unsigned       CNT_W     = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
    localparam logic [PAGE_W-1:0] PAGE_LAST = PAGE_W'(2 * NUM_WORDS - 1);
    localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(TICKS_PER_STEP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_WRITE,
        S_HOLD,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [PAGE_W-1:0] r_page;
    logic [CNT_W-1:0]  r_tick;
    logic              r_stop_pend;

    logic [15:0]       w_half;
    logic [31:0]       w_seg;
    logic [ADDR_W-1:0] w_next_addr;

    // Active-low gfedcba, bit 7 always 0.
    function automatic logic [7:0] seg7(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'h0:    s = 8'h40;
            4'h1:    s = 8'h79;
            4'h2:    s = 8'h24;
            4'h3:    s = 8'h30;
            4'h4:    s = 8'h19;
            4'h5:    s = 8'h12;
            4'h6:    s = 8'h02;
            4'h7:    s = 8'h78;
            4'h8:    s = 8'h00;
            4'h9:    s = 8'h10;
            4'hA:    s = 8'h08;
            4'hB:    s = 8'h03;
            4'hC:    s = 8'h46;
            4'hD:    s = 8'h21;
            4'hE:    s = 8'h06;
            default: s = 8'h0E;
        endcase
        return s;
    endfunction

    assign w_half      = r_page[0] ? hash_word_in[15:0] : hash_word_in[31:16];
    assign w_seg       = {seg7(w_half[15:12]), seg7(w_half[11:8]), seg7(w_half[7:4]), seg7(w_half[3:0])};
    assign w_next_addr = ADDR_W'((r_page + PAGE_W'(1)) >> 1);
    assign pio_address = '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_page         <= '0;
            r_tick         <= '0;
            r_stop_pend    <= 1'b0;
            hash_word_addr <= '0;
            pio_chipselect <= 1'b0;
            pio_write_n    <= 1'b1;
            pio_writedata  <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !stop) begin
                        r_state        <= S_FETCH;
                        r_page         <= '0;
                        r_stop_pend    <= 1'b0;
                        hash_word_addr <= '0;
                        busy           <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (stop) begin
                        r_state <= S_IDLE;
                        r_page  <= '0;
                        busy    <= 1'b0;
                    end else begin
                        r_state <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    if (stop) begin
                        r_state <= S_IDLE;
                        r_page  <= '0;
                        busy    <= 1'b0;
                    end else begin
                        pio_writedata  <= w_seg;
                        pio_chipselect <= 1'b1;
                        pio_write_n    <= 1'b0;
                        r_state        <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    // A stop seen mid-transfer is remembered so the bus cycle still completes cleanly.
                    if (!pio_waitrequest) begin
                        pio_chipselect <= 1'b0;
                        pio_write_n    <= 1'b1;
                        r_tick         <= '0;
                        if (stop || r_stop_pend) begin
                            r_state     <= S_IDLE;
                            r_page      <= '0;
                            r_stop_pend <= 1'b0;
                            busy        <= 1'b0;
                        end else begin
                            r_state <= S_HOLD;
                        end
                    end else if (stop) begin
                        r_stop_pend <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (stop) begin
                        r_state <= S_IDLE;
                        r_page  <= '0;
                        busy    <= 1'b0;
                    end else if (r_tick == TICK_LAST) begin
                        if (r_page == PAGE_LAST) begin
`ifdef G25_HEX_LOOP_EN
                            r_state        <= S_FETCH;
                            r_page         <= '0;
                            hash_word_addr <= '0;
                            done           <= 1'b1;
`else
                            r_state <= S_DONE;
                            done    <= 1'b1;
                            busy    <= 1'b0;
`endif
                        end else begin
                            r_state        <= S_FETCH;
                            r_page         <= r_page + PAGE_W'(1);
                            hash_word_addr <= w_next_addr;
                        end
                    end else begin
                        r_tick <= r_tick + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_page  <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_g25_hex_page_sequencer.sv
// Directed/randomized bench for g25_hex_page_sequencer; expected pages and timing come from a behavioural model.
module tb_g25_hex_page_sequencer;

    localparam int unsigned T  = 4;
    localparam int unsigned NW = 8;
    localparam int          HN = 4096;

    logic        clk = 1'b0;
    logic        reset, start, stop;
    logic [2:0]  hash_word_addr;
    logic [31:0] hash_word_in;
    logic [1:0]  pio_address;
    logic        pio_chipselect, pio_write_n;
    logic [31:0] pio_writedata;
    logic        pio_waitrequest = 1'b0;
    logic        busy, done;

    logic [31:0] mem [NW];
    logic [7:0]  segtab [16] = '{8'h40, 8'h79, 8'h24, 8'h30, 8'h19, 8'h12, 8'h02, 8'h78,
                                 8'h00, 8'h10, 8'h08, 8'h03, 8'h46, 8'h21, 8'h06, 8'h0E};

    int          cyc = 0;
    int          n_cmp, n_fail;
    int          wcyc[$];
    logic [31:0] wdata[$];
    int          wbase;
    int          stall_plan [20];
    int          stall_cnt = 0;
    bit          busy_h [HN];
    bit          done_h [HN];
    bit          cs_h [HN];
    bit          wn_h [HN];
    logic [2:0]  addr_h [HN];
    logic [31:0] wd_h [HN];

    g25_hex_page_sequencer #(.TICKS_PER_STEP(T), .NUM_WORDS(NW)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .stop            (stop),
        .hash_word_addr  (hash_word_addr),
        .hash_word_in    (hash_word_in),
        .pio_address     (pio_address),
        .pio_chipselect  (pio_chipselect),
        .pio_write_n     (pio_write_n),
        .pio_writedata   (pio_writedata),
        .pio_waitrequest (pio_waitrequest),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) hash_word_in <= mem[hash_word_addr];

    // Slave model plus history recorder: stalls write #n for stall_plan[n] cycles.
    always @(posedge clk) begin
        int idx;
        int lim;
        #1;
        idx = wcyc.size() - wbase;
        lim = (idx >= 0 && idx < 20) ? stall_plan[idx] : 0;
        if (!pio_chipselect) stall_cnt = 0;
        if (pio_chipselect && stall_cnt < lim) begin
            pio_waitrequest = 1'b1;
            stall_cnt++;
        end else begin
            pio_waitrequest = 1'b0;
        end
        if (cyc < HN) begin
            busy_h[cyc] = busy;
            done_h[cyc] = done;
            cs_h[cyc]   = pio_chipselect;
            wn_h[cyc]   = pio_write_n;
            addr_h[cyc] = hash_word_addr;
            wd_h[cyc]   = pio_writedata;
        end
        if (pio_chipselect && !pio_write_n && !pio_waitrequest) begin
            wcyc.push_back(cyc);
            wdata.push_back(pio_writedata);
            stall_cnt = 0;
        end
    end

    function automatic logic [31:0] exp_data(input int p);
        logic [31:0] w;
        int unsigned half;
        logic [31:0] r;
        w    = mem[p / 2];
        half = (p % 2 == 0) ? (w >> 16) : (w & 32'hFFFF);
        r    = '0;
        for (int d = 0; d < 4; d++) r = r | (32'(segtab[(half >> (4 * d)) % 16]) << (8 * d));
        return r;
    endfunction

    function automatic int count_done(input int a, input int b);
        int n = 0;
        for (int i = a; i <= b && i < HN; i++) if (done_h[i]) n++;
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_writes(input int n, input int budget, input string tag);
        int k = 0;
        while ((wcyc.size() - wbase) < n && k < budget) begin
            tick();
            k++;
        end
        check(tag, 32'(wcyc.size() - wbase), 32'(n));
    endtask

    initial begin
        int c0, s, a, last_a, d, n;
        reset = 1'b1; start = 1'b0; stop = 1'b0;
        n_cmp = 0; n_fail = 0; wbase = 0;
        foreach (stall_plan[i]) stall_plan[i] = 0;
        mem[0] = 32'h01234567;
        mem[1] = 32'h89ABCDEF;
        for (int i = 2; i < NW; i++) mem[i] = $urandom;

        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_cs", pio_chipselect, 0);
        check("rst_wn", pio_write_n, 1);
        check("rst_paddr", pio_address, 0);
        check("rst_wd", pio_writedata, 0);
        check("rst_haddr", hash_word_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);

        // Full pass, first write stalled 5 cycles, random stalls elsewhere, redundant start mid-run.
        wbase = wcyc.size();
        stall_plan[0] = 5;
        for (int i = 1; i < 16; i++) stall_plan[i] = $urandom_range(0, 2);
        c0 = cyc;
        start = 1'b1; tick(); start = 1'b0;
        wait_writes(3, 100, "ign_wait");
        start = 1'b1; tick(); start = 1'b0;
        wait_writes(16, 400, "run16_wait");
        repeat (T + 8) tick();

        check("first_cs_pre", cs_h[c0 + 2], 0);
        check("first_cs", cs_h[c0 + 3], 1);
        check("first_wn", wn_h[c0 + 3], 0);
        check("first_acc_cyc", 32'(wcyc[wbase]), 32'(c0 + 8));
        n = 0;
        for (int i = c0 + 3; i <= c0 + 8; i++) if (cs_h[i] && !wn_h[i] && wd_h[i] === 32'h40792430) n++;
        check("stall_stable", 32'(n), 6);
        check("after_acc_cs", cs_h[c0 + 9], 0);
        check("pg0_lit", wdata[wbase + 0], 32'h40792430);
        check("pg1_lit", wdata[wbase + 1], 32'h19120278);
        check("pg2_lit", wdata[wbase + 2], 32'h00100803);
        check("pg3_lit", wdata[wbase + 3], 32'h4621060E);

        s = c0 + 3;
        last_a = 0;
        for (int k = 0; k < 16; k++) begin
            a = s + stall_plan[k];
            check($sformatf("addr_p%0d", k), addr_h[s - 2], 32'(k >> 1));
            check($sformatf("wcyc_p%0d", k), 32'(wcyc[wbase + k]), 32'(a));
            check($sformatf("wdata_p%0d", k), wdata[wbase + k], exp_data(k));
            last_a = a;
            s = a + T + 3;
        end
        d = last_a + T + 1;
`ifdef G25_HEX_LOOP_EN
        check("loop_done", done_h[d], 1);
        check("loop_busy", busy_h[d], 1);
        wait_writes(17, 50, "loop17_wait");
        check("loop_wcyc", 32'(wcyc[wbase + 16]), 32'(d + 2));
        check("loop_wdata", wdata[wbase + 16], exp_data(0));
        stop = 1'b1; tick(); stop = 1'b0;
        tick();
        check("loop_stop_busy", busy, 0);
`else
        check("done_pulse", done_h[d], 1);
        check("done_after", done_h[d + 1], 0);
        check("busy_at_done", busy_h[d], 0);
        check("busy_before_done", busy_h[d - 1], 1);
        check("done_count", 32'(count_done(c0, cyc)), 1);
        check("no_17th", 32'(wcyc.size() - wbase), 16);
`endif
        foreach (stall_plan[i]) stall_plan[i] = 0;
        repeat (4) tick();

        // Stop during HOLD of page 5.
        wbase = wcyc.size();
        c0 = cyc;
        start = 1'b1; tick(); start = 1'b0;
        wait_writes(6, 200, "p5_wait");
        check("p5_cyc", 32'(wcyc[wbase + 5]), 32'(c0 + 3 + 5 * (T + 3)));
        tick();
        stop = 1'b1; tick(); stop = 1'b0;
        check("hstop_busy", busy, 0);
        check("hstop_cs", pio_chipselect, 0);
        repeat (40) tick();
        check("hstop_nwr", 32'(wcyc.size() - wbase), 6);
        check("hstop_done", 32'(count_done(c0, cyc)), 0);

        // Restart from page 0; stop while the first write is stalled.
        wbase = wcyc.size();
        stall_plan[0] = 3;
        c0 = cyc;
        start = 1'b1; tick(); start = 1'b0;
        repeat (3) tick();
        check("ws_cs", pio_chipselect, 1);
        check("rs_addr", addr_h[c0 + 1], 0);
        stop = 1'b1; tick(); stop = 1'b0;
        wait_writes(1, 20, "ws_wait");
        check("ws_wcyc", 32'(wcyc[wbase]), 32'(c0 + 6));
        check("ws_wdata", wdata[wbase], exp_data(0));
        tick();
        check("ws_busy", busy, 0);
        repeat (30) tick();
        check("ws_nwr", 32'(wcyc.size() - wbase), 1);
        check("ws_done", 32'(count_done(c0, cyc)), 0);
        stall_plan[0] = 0;

        // Simultaneous start and stop in IDLE.
        wbase = wcyc.size();
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        repeat (8) tick();
        check("ss_busy", busy, 0);
        check("ss_nwr", 32'(wcyc.size() - wbase), 0);

        // Reset while WRITE is stalled.
        wbase = wcyc.size();
        stall_plan[0] = 4;
        c0 = cyc;
        start = 1'b1; tick(); start = 1'b0;
        repeat (3) tick();
        check("rw_cs_pre", pio_chipselect, 1);
        reset = 1'b1; tick(); reset = 1'b0;
        check("rw_cs", pio_chipselect, 0);
        check("rw_wn", pio_write_n, 1);
        check("rw_wd", pio_writedata, 0);
        check("rw_busy", busy, 0);
        repeat (20) tick();
        check("rw_nwr", 32'(wcyc.size() - wbase), 0);
        check("rw_done", 32'(count_done(c0, cyc)), 0);
        stall_plan[0] = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
